clint_bus_master: RTL and testbench
===================================

# clint_bus_master

Bus initiator for the CLINT port. Accepts word and doubleword load/store requests from the core's LSU over a valid/ready handshake. Sequences them into single-word CLINT bus cycles (`bus_clint_*`), and returns one response per request.

- Doubleword reads of `mtime` use a hi-lo-hi consistency loop.
- Doubleword writes of `mtimecmp` use the glitch-free three-write order, so no spurious timer interrupt is raised.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 1: requests in flight. Fixed at 1; a new request is accepted only in IDLE.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  `ADDR_WIDTH`  byte address, CLINT-relative.
- `req_size`  in  `SIZE_WIDTH`  access size: 'b10 = word, 'b11 = doubleword; anything else is an error.
- `req_wdata`  in  `2*REG_DATA_WIDTH`  store data; low word at `req_addr`.
- `rsp_valid`  out  1  response present; held until `rsp_ready`.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  `2*REG_DATA_WIDTH`  load data; zero-extended for word loads; 0 for stores and errors.
- `rsp_error`  out  1  misaligned address or unsupported size.
- `bus_clint_read_addr`, `bus_clint_write_addr`  out  `ADDR_WIDTH`  CLINT address.
- `bus_clint_read_size`, `bus_clint_write_size`  out  `SIZE_WIDTH`  always 'b10 while the matching strobe is high.
- `bus_clint_data`  out  `REG_DATA_WIDTH`  write word.
- `bus_clint_rd`, `bus_clint_wr`  out  1  one-cycle strobes; never high together.
- `clint_bus_data`  in  `BUS_DATA_WIDTH`  registered CLINT read data; low `REG_DATA_WIDTH` bits used.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_CAP, WR_ISSUE, RESP.
  - A step counter and a per-request step list select the address and data for each bus cycle.
- On acceptance, latch the request.
  - Error if size is not 'b10 or 'b11.
  - Error if a word access has `addr[1:0]` ≠ 0.
  - Error if a doubleword access has `addr[2:0]` ≠ 0.
  - An error request goes straight to RESP with `rsp_error`=1 and issues no bus cycle.
- Word load: one read of `addr`.
- Word store: one write of `addr`.
- Doubleword load of `MTIME_ADDR`:
  - Read hi (+4), then lo, then hi again.
  - If the two hi values are equal, return {hi1, lo}.
  - Otherwise restart the hi-lo-hi sequence. No retry bound.
- Doubleword load, any other address: read lo, then hi; return {hi, lo}.
- Doubleword store of `MTIMECMP_ADDR`:
  - Write lo = all-ones.
  - Write hi = `wdata[63:32]`.
  - Write lo = `wdata[31:0]`.
- Doubleword store, any other address: write lo, then hi.
- RESP: `rsp_valid`=1 and outputs stable until `rsp_valid && rsp_ready`; then go to IDLE.
- All bus outputs are registered. Outside a strobe, addresses, sizes and data are 0.

## Timing
- Acceptance edge = E0. Cycle n is the cycle after edge En-1.
- Read step: `bus_clint_rd` high in its issue cycle. `clint_bus_data` is valid in the next cycle (RD_CAP) and is captured at the end of that cycle. Each read step takes 2 cycles.
- Write step: `bus_clint_wr` high for 1 cycle; the CLINT updates at that edge.
- First `rsp_valid` cycle (with `rsp_ready` held high):

| Access | First `rsp_valid` cycle |
|---|---|
| Word load | 3 |
| Word store | 2 |
| Error | 1 |
| Generic doubleword load | 5 |
| `mtime` doubleword load, no retry | 7 (+6 per retry) |
| Generic doubleword store | 3 |
| `mtimecmp` doubleword store | 4 |

- `req_ready` returns high the cycle after the response handshake.
- Reset values: `req_ready`=0 while reset is asserted, 1 after release. `rsp_valid`, `rsp_error`, `rsp_rdata`, all `bus_clint_*` outputs and the internal state = 0 / IDLE.
- Reset mid-operation: outputs clear immediately (asynchronously) and the in-flight request is dropped with no response. A partially written `mtimecmp` is left as written.

## Structure
- Shared package `clint_pkg`:
  - `MSIP_ADDR`, `MTIMECMP_ADDR`, `MTIME_ADDR`.
  - Size encodings `SIZE_WORD`='b10, `SIZE_DWORD`='b11.
  - FSM state enum.
  - The CLINT itself imports the same address constants.
- No sub-module: a single FSM plus step sequencer, about 200–300 lines.

## Test plan
- Word load of `MSIP_ADDR`:
  - After a word store of 1 to `MSIP_ADDR` (`bus_clint_wr` only in cycle 1, `rsp_valid` in cycle 2), the load returns `rsp_rdata`=1.
  - The load's `bus_clint_rd` is high only in cycle 1 and `rsp_valid` is high in cycle 3.
- Doubleword store 0x0000_0001_0000_0005 to `MTIMECMP_ADDR`:
  - Write sequence 0xFFFFFFFF@0x4000, 0x1@0x4004, 0x5@0x4000.
  - Timer request never asserts during the sequence while `mtime` < 2^32.
- Doubleword load of `mtime` with `mtime` preset to 0x0000_0000_FFFF_FFFD:
  - Hi changes between reads, so exactly one retry.
  - Final value has hi=1; `rsp_valid` in cycle 13.
- Error cases: addr 0x4002 size 'b10; addr 0x4004 size 'b11; size 'b00.
  - Each returns `rsp_error`=1 in cycle 1 and issues no strobes.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles.
  - `rsp_*` stays stable and `req_ready`=0 throughout.
  - Handshake on the 6th cycle; `req_ready`=1 on the next cycle.
- Assert `rst` low during the hi-lo-hi read:
  - Strobes drop immediately and no response is produced.
  - After release, a word load of `MSIP_ADDR` returns 0.

Source files
------------

// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared CLINT address map, size encodings and bus-master types
package clint_pkg;

    localparam int CLINT_ADDR_WIDTH = 16;
    localparam int CLINT_SIZE_WIDTH = 2;
    localparam int CLINT_REG_WIDTH  = 32;
    localparam int CLINT_BUS_WIDTH  = 64;

    localparam logic [CLINT_ADDR_WIDTH-1:0] MSIP_ADDR     = 16'h0000;
    localparam logic [CLINT_ADDR_WIDTH-1:0] MTIMECMP_ADDR = 16'h4000;
    localparam logic [CLINT_ADDR_WIDTH-1:0] MTIME_ADDR    = 16'hBFF8;

    localparam logic [CLINT_SIZE_WIDTH-1:0] SIZE_WORD  = 2'b10;
    localparam logic [CLINT_SIZE_WIDTH-1:0] SIZE_DWORD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_ISSUE, ST_RD_CAP, ST_WR_ISSUE, ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        OP_WORD_RD, OP_WORD_WR, OP_DW_RD, OP_MTIME_RD, OP_DW_WR, OP_MTIMECMP_WR, OP_ERROR
    } op_e;

    // Step list: does this step target the high word (addr + 4)?
    function automatic logic step_hi(op_e op, logic [1:0] step);
        case (op)
            OP_DW_RD, OP_DW_WR, OP_MTIMECMP_WR: return step == 2'd1;
            OP_MTIME_RD:                        return step != 2'd1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] last_step(op_e op);
        case (op)
            OP_DW_RD, OP_DW_WR:          return 2'd1;
            OP_MTIME_RD, OP_MTIMECMP_WR: return 2'd2;
            default:                     return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/clint_bus_master.sv
// rtl/clint_bus_master.sv - LSU-to-CLINT initiator splitting requests into word bus cycles
module clint_bus_master
    import clint_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 1,
    parameter int ADDR_WIDTH      = CLINT_ADDR_WIDTH,
    parameter int SIZE_WIDTH      = CLINT_SIZE_WIDTH,
    parameter int REG_DATA_WIDTH  = CLINT_REG_WIDTH,
    parameter int BUS_DATA_WIDTH  = CLINT_BUS_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic [SIZE_WIDTH-1:0]       req_size,
    input  logic [2*REG_DATA_WIDTH-1:0] req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [2*REG_DATA_WIDTH-1:0] rsp_rdata,
    output logic                        rsp_error,
    output logic [ADDR_WIDTH-1:0]       bus_clint_read_addr,
    output logic [ADDR_WIDTH-1:0]       bus_clint_write_addr,
    output logic [SIZE_WIDTH-1:0]       bus_clint_read_size,
    output logic [SIZE_WIDTH-1:0]       bus_clint_write_size,
    output logic [REG_DATA_WIDTH-1:0]   bus_clint_data,
    output logic                        bus_clint_rd,
    output logic                        bus_clint_wr,
    input  logic [BUS_DATA_WIDTH-1:0]   clint_bus_data
);

    localparam int RW = REG_DATA_WIDTH;

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [1:0]             step_q, step_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [2*RW-1:0]        wdata_q, wdata_d;
    logic [RW-1:0]          lo_q, lo_d, hi_q, hi_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_error_q, rsp_error_d;
    logic [2*RW-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic                   rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [SIZE_WIDTH-1:0]  rd_size_q, rd_size_d, wr_size_q, wr_size_d;
    logic [RW-1:0]          bus_data_q, bus_data_d;
    logic [RW-1:0]          cap_word;
    logic                   unused_bits;

    assign cap_word    = clint_bus_data[RW-1:0];
    assign unused_bits = ^{clint_bus_data[BUS_DATA_WIDTH-1:RW], MAX_OUTSTANDING != 1};

    // The mtimecmp sequence parks lo at all-ones first so the compare can never pass mid-update.
    function automatic logic [RW-1:0] wr_word(op_e op, logic [1:0] step, logic [2*RW-1:0] wd);
        if (op == OP_MTIMECMP_WR && step == 2'd0) return '1;
        return step_hi(op, step) ? wd[2*RW-1:RW] : wd[RW-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        step_d      = step_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: if (req_valid && req_ready_q) begin
                addr_d      = req_addr;
                wdata_d     = req_wdata;
                step_d      = 2'd0;
                lo_d        = '0;
                hi_d        = '0;
                rsp_rdata_d = '0;
                rsp_error_d = 1'b0;
                if (req_size == SIZE_WIDTH'(SIZE_WORD) && req_addr[1:0] == 2'b00)
                    op_d = req_write ? OP_WORD_WR : OP_WORD_RD;
                else if (req_size == SIZE_WIDTH'(SIZE_DWORD) && req_addr[2:0] == 3'b000) begin
                    if (req_write)
                        op_d = (req_addr == ADDR_WIDTH'(MTIMECMP_ADDR)) ? OP_MTIMECMP_WR : OP_DW_WR;
                    else
                        op_d = (req_addr == ADDR_WIDTH'(MTIME_ADDR)) ? OP_MTIME_RD : OP_DW_RD;
                end else
                    op_d = OP_ERROR;
                if (op_d == OP_ERROR) begin
                    rsp_error_d = 1'b1;
                    state_d     = ST_RESP;
                end else
                    state_d = req_write ? ST_WR_ISSUE : ST_RD_ISSUE;
            end
            ST_RD_ISSUE: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                if (op_q == OP_MTIME_RD) begin
                    if (step_q == 2'd0) hi_d = cap_word;
                    else if (step_q == 2'd1) lo_d = cap_word;
                end else if (step_hi(op_q, step_q))
                    hi_d = cap_word;
                else
                    lo_d = cap_word;
                // A carry into mtime hi between the two hi reads forces a fresh hi-lo-hi pass.
                if (op_q == OP_MTIME_RD && step_q == 2'd2 && cap_word != hi_q) begin
                    step_d  = 2'd0;
                    state_d = ST_RD_ISSUE;
                end else if (step_q == last_step(op_q)) begin
                    rsp_rdata_d = {hi_d, lo_d};
                    state_d     = ST_RESP;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                if (step_q == last_step(op_q))
                    state_d = ST_RESP;
                else
                    step_d = step_q + 2'd1;
            end
            ST_RESP: if (rsp_ready) begin
                rsp_error_d = 1'b0;
                rsp_rdata_d = '0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        rd_addr_d   = '0;
        wr_addr_d   = '0;
        rd_size_d   = '0;
        wr_size_d   = '0;
        bus_data_d  = '0;
        if (state_d == ST_RD_ISSUE) begin
            rd_d      = 1'b1;
            rd_addr_d = addr_d + (step_hi(op_d, step_d) ? ADDR_WIDTH'(4) : '0);
            rd_size_d = SIZE_WIDTH'(SIZE_WORD);
        end
        if (state_d == ST_WR_ISSUE) begin
            wr_d       = 1'b1;
            wr_addr_d  = addr_d + (step_hi(op_d, step_d) ? ADDR_WIDTH'(4) : '0);
            wr_size_d  = SIZE_WIDTH'(SIZE_WORD);
            bus_data_d = wr_word(op_d, step_d, wdata_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WORD_RD;
            step_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            rd_size_q   <= '0;
            wr_size_q   <= '0;
            bus_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            step_q      <= step_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            rd_size_q   <= rd_size_d;
            wr_size_q   <= wr_size_d;
            bus_data_q  <= bus_data_d;
        end
    end

    assign req_ready            = req_ready_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_error            = rsp_error_q;
    assign rsp_rdata            = rsp_rdata_q;
    assign bus_clint_rd         = rd_q;
    assign bus_clint_wr         = wr_q;
    assign bus_clint_read_addr  = rd_addr_q;
    assign bus_clint_write_addr = wr_addr_q;
    assign bus_clint_read_size  = rd_size_q;
    assign bus_clint_write_size = wr_size_q;
    assign bus_clint_data       = bus_data_q;

endmodule

// File: tb/tb_clint_bus_master.sv
// tb/tb_clint_bus_master.sv - directed table-driven bench for clint_bus_master with a CLINT model
module tb_clint_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
    logic [15:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_error, bus_clint_rd, bus_clint_wr;
    logic [63:0] rsp_rdata;
    logic [15:0] bus_clint_read_addr, bus_clint_write_addr;
    logic [1:0]  bus_clint_read_size, bus_clint_write_size;
    logic [31:0] bus_clint_data;
    logic [63:0] clint_bus_data = '0;

    clint_bus_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .bus_clint_read_addr(bus_clint_read_addr), .bus_clint_write_addr(bus_clint_write_addr),
        .bus_clint_read_size(bus_clint_read_size), .bus_clint_write_size(bus_clint_write_size),
        .bus_clint_data(bus_clint_data), .bus_clint_rd(bus_clint_rd), .bus_clint_wr(bus_clint_wr),
        .clint_bus_data(clint_bus_data)
    );

    always #5 clk = ~clk;

    // CLINT model: registered read data, free-running mtime, msip cleared by reset.
    logic [31:0] msip = '0;
    logic [63:0] mtime = '0, mtimecmp = '1, mtime_load_val = '0;
    logic        mtime_load = 1'b0;
    logic [31:0] mem [0:63] = '{default: 32'h0};
    logic [47:0] wlog [$];
    logic        irq;
    assign irq = (mtime >= mtimecmp);

    function automatic logic [31:0] rd_word(logic [15:0] a);
        case (a)
            16'h0000: return msip;
            16'h4000: return mtimecmp[31:0];
            16'h4004: return mtimecmp[63:32];
            16'hBFF8: return mtime[31:0];
            16'hBFFC: return mtime[63:32];
            default:  return mem[a[7:2]];
        endcase
    endfunction

    always @(posedge clk) begin
        mtime <= mtime_load ? mtime_load_val : mtime + 64'd1;
        if (!rst) msip <= '0;
        else begin
            if (bus_clint_rd) clint_bus_data <= {32'hDEADBEEF, rd_word(bus_clint_read_addr)};
            if (bus_clint_wr) begin
                wlog.push_back({bus_clint_write_addr, bus_clint_data});
                case (bus_clint_write_addr)
                    16'h0000: msip <= bus_clint_data;
                    16'h4000: mtimecmp[31:0] <= bus_clint_data;
                    16'h4004: mtimecmp[63:32] <= bus_clint_data;
                    default:  mem[bus_clint_write_addr[7:2]] <= bus_clint_data;
                endcase
            end
        end
    end

    int  pass_cnt = 0, total_cnt = 0, viol = 0, irq_viol = 0;
    logic irq_watch = 1'b0;

    always @(negedge clk) if (rst) begin
        if (bus_clint_rd && bus_clint_wr) viol++;
        if (bus_clint_rd && bus_clint_read_size != 2'b10) viol++;
        if (bus_clint_wr && bus_clint_write_size != 2'b10) viol++;
        if (!bus_clint_rd && (bus_clint_read_addr != 0 || bus_clint_read_size != 0)) viol++;
        if (!bus_clint_wr && (bus_clint_write_addr != 0 || bus_clint_write_size != 0 || bus_clint_data != 0)) viol++;
        if (irq_watch && irq) irq_viol++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic w, input logic [15:0] a, input logic [1:0] s, input logic [63:0] wd,
                           input logic preset, output logic [63:0] rd, output logic er, output int lat,
                           output int nrd, output int nwr, output logic rdy);
        rd = '0; er = 1'b0; lat = -1; nrd = 0; nwr = 0; rdy = 1'b0;
        for (int i = 0; i < 50 && !req_ready; i++) cyc();
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = wd; mtime_load = preset;
        cyc();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0; mtime_load = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (bus_clint_rd) nrd++;
            if (bus_clint_wr) nwr++;
            if (rsp_valid) begin
                lat = n; rd = rsp_rdata; er = rsp_error;
                break;
            end
            cyc();
        end
        cyc();
        rdy = req_ready;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    vec_t        vecs [10];
    logic [63:0] rd;
    logic        er, rdy;
    int          lat, nrd, nwr, seen;
    logic [63:0] held_rdata;

    initial begin
        vecs[0] = '{1'b1, 16'h0000, 2'b10, 64'h1,                   64'h0,                   1'b0, 2, 0, 1};
        vecs[1] = '{1'b0, 16'h0000, 2'b10, 64'h0,                   64'h1,                   1'b0, 3, 1, 0};
        vecs[2] = '{1'b1, 16'h4008, 2'b11, 64'h1122334455667788,    64'h0,                   1'b0, 3, 0, 2};
        vecs[3] = '{1'b0, 16'h4008, 2'b11, 64'h0,                   64'h1122334455667788,    1'b0, 5, 2, 0};
        vecs[4] = '{1'b0, 16'h400C, 2'b10, 64'h0,                   64'h11223344,            1'b0, 3, 1, 0};
        vecs[5] = '{1'b1, 16'h4002, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b1, 1, 0, 0};
        vecs[6] = '{1'b0, 16'h4004, 2'b11, 64'h0,                   64'h0,                   1'b1, 1, 0, 0};
        vecs[7] = '{1'b0, 16'h0000, 2'b00, 64'h0,                   64'h0,                   1'b1, 1, 0, 0};
        vecs[8] = '{1'b1, 16'h4010, 2'b10, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0,                   1'b0, 2, 0, 1};
        vecs[9] = '{1'b0, 16'h4010, 2'b11, 64'h0,                   64'h0000_0000_CCCC_DDDD, 1'b0, 5, 2, 0};

        cyc(); cyc();
        check("reset_req_ready", {63'h0, req_ready}, 64'h0);
        check("reset_rsp", {rsp_rdata[62:0], rsp_valid}, 64'h0);
        check("reset_rsp_error", {63'h0, rsp_error}, 64'h0);
        check("reset_bus", {bus_clint_read_addr, bus_clint_write_addr, bus_clint_data}, 64'h0);
        rst = 1'b1;
        cyc();
        check("release_req_ready", {63'h0, req_ready}, 64'h1);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, 1'b0, rd, er, lat, nrd, nwr, rdy);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_error", i), {63'h0, er}, {63'h0, vecs[i].err});
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_reads", i), 64'(nrd), 64'(vecs[i].nrd));
            check($sformatf("v%0d_writes", i), 64'(nwr), 64'(vecs[i].nwr));
            check($sformatf("v%0d_ready_after", i), {63'h0, rdy}, 64'h1);
        end

        // mtimecmp: park at {0, all-ones}, then move to {1, 5}; a lo-first update would fire the timer.
        mtime_load_val = 64'h100;
        run_req(1'b1, 16'h4000, 2'b11, 64'h0000_0000_FFFF_FFFF, 1'b1, rd, er, lat, nrd, nwr, rdy);
        check("cmp_park_latency", 64'(lat), 64'd4);
        wlog.delete();
        irq_watch = 1'b1;
        run_req(1'b1, 16'h4000, 2'b11, 64'h0000_0001_0000_0005, 1'b0, rd, er, lat, nrd, nwr, rdy);
        irq_watch = 1'b0;
        check("cmp_latency", 64'(lat), 64'd4);
        check("cmp_writes", 64'(nwr), 64'd3);
        check("cmp_wlog_len", 64'(wlog.size()), 64'd3);
        if (wlog.size() == 3) begin
            check("cmp_w0", {16'h0, wlog[0]}, {16'h0, 16'h4000, 32'hFFFF_FFFF});
            check("cmp_w1", {16'h0, wlog[1]}, {16'h0, 16'h4004, 32'h0000_0001});
            check("cmp_w2", {16'h0, wlog[2]}, {16'h0, 16'h4000, 32'h0000_0005});
        end
        check("cmp_no_irq", 64'(irq_viol), 64'd0);
        run_req(1'b0, 16'h4000, 2'b11, 64'h0, 1'b0, rd, er, lat, nrd, nwr, rdy);
        check("cmp_readback", rd, 64'h0000_0001_0000_0005);

        // mtime carries from 0xFFFF_FFFF into hi between the first hi and second hi reads.
        mtime_load_val = 64'h0000_0000_FFFF_FFFD;
        run_req(1'b0, 16'hBFF8, 2'b11, 64'h0, 1'b1, rd, er, lat, nrd, nwr, rdy);
        check("mtime_rdata", rd, 64'h0000_0001_0000_0005);
        check("mtime_latency", 64'(lat), 64'd13);
        check("mtime_reads", 64'(nrd), 64'd6);

        // Response backpressure on a word load of msip.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 16'h0000; req_size = 2'b10;
        cyc();
        req_valid = 1'b0; req_size = '0;
        for (int i = 0; i < 10 && !rsp_valid; i++) cyc();
        held_rdata = rsp_rdata;
        check("bp_rdata", held_rdata, 64'h1);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("bp_c%0d", k), {rsp_rdata[61:0], rsp_valid, req_ready}, {held_rdata[61:0], 2'b10});
            cyc();
        end
        rsp_ready = 1'b1;
        check("bp_c6_valid", {63'h0, rsp_valid}, 64'h1);
        cyc();
        check("bp_ready_after", {62'h0, req_ready, rsp_valid}, 64'h2);

        // Asynchronous reset during the hi-lo-hi read.
        req_valid = 1'b1; req_addr = 16'hBFF8; req_size = 2'b11;
        cyc();
        req_valid = 1'b0; req_addr = '0; req_size = '0;
        cyc(); cyc();
        check("rst_mid_rd_active", {63'h0, bus_clint_rd}, 64'h1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_outputs", {59'h0, bus_clint_rd, bus_clint_wr, rsp_valid, req_ready, rsp_error}, 64'h0);
        check("rst_mid_addr", {48'h0, bus_clint_read_addr}, 64'h0);
        cyc();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid) seen++;
            cyc();
        end
        check("rst_no_response", 64'(seen), 64'd0);
        run_req(1'b0, 16'h0000, 2'b10, 64'h0, 1'b0, rd, er, lat, nrd, nwr, rdy);
        check("rst_msip_load", rd, 64'h0);
        check("rst_msip_latency", 64'(lat), 64'd3);

        check("bus_protocol", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
